// File: rtl/dual_motor_pwm_if.sv
// rtl/dual_motor_pwm_if.sv - motor command bundle: per-channel magnitude/sign plus capture strobe
interface dual_motor_pwm_if;
    logic [7:0] motor1_count;
    logic       motor1_sign;
    logic [7:0] motor2_count;
    logic       motor2_sign;
    logic       cmd_valid;

    modport master (
        output motor1_count, motor1_sign, motor2_count, motor2_sign, cmd_valid
    );

    modport slave (
        input motor1_count, motor1_sign, motor2_count, motor2_sign, cmd_valid
    );
endinterface

// File: rtl/dual_motor_pwm.sv
// rtl/dual_motor_pwm.sv - two-channel PWM / H-bridge driver with reversal dead-time
// Optional command watchdog is compiled in with `define WATCHDOG_EN.
module dual_motor_pwm #(
    parameter int PRESCALE        = 4,
    parameter int DEADTIME_CYCLES = 64,
    parameter int WDT_PERIODS     = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    dual_motor_pwm_if.slave       cmd,
    output logic                  enable12,
    output logic                  enable34,
    output logic                  a1,
    output logic                  a2,
    output logic                  a3,
    output logic                  a4,
    output logic                  period_start,
    output logic                  wdt_tripped
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW    = $clog2(DEADTIME_CYCLES + 1);

    if (PRESCALE < 1 || DEADTIME_CYCLES < 1 || WDT_PERIODS < 1) begin : g_param_check
        $error("dual_motor_pwm: PRESCALE, DEADTIME_CYCLES and WDT_PERIODS must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } ch_state_t;

    logic [PRE_W-1:0] pre_q;
    logic [7:0]       cnt_q;
    logic             tick;
    logic             boundary;

    logic [1:0][7:0]  sh_duty;
    logic [1:0]       sh_sign;
    logic [1:0][7:0]  duty_a, duty_d;
    logic [1:0]       sign_a, sign_d;

    ch_state_t        state_q [2];
    ch_state_t        state_d [2];
    logic [DW-1:0]    dead_q  [2];
    logic [DW-1:0]    dead_d  [2];

    logic [1:0]       en_d;
    logic [1:0][1:0]  pins_d;
    logic             force_idle;

    assign tick     = (pre_q == PRE_W'(PRESCALE - 1));
    assign boundary = tick && (cnt_q == 8'd254);

`ifdef WATCHDOG_EN
    localparam int WW = $clog2(WDT_PERIODS + 1);

    logic [WW-1:0] wdt_cnt_q;
    logic          wdt_q;
    logic          trip_now;

    // A strobe on the tripping boundary counts as fresh traffic, so no trip.
    assign trip_now = boundary && !cmd.cmd_valid && (wdt_cnt_q == WW'(WDT_PERIODS - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wdt_cnt_q <= '0;
            wdt_q     <= 1'b0;
        end else begin
            if (cmd.cmd_valid) begin
                wdt_cnt_q <= '0;
            end else if (boundary && (wdt_cnt_q != WW'(WDT_PERIODS))) begin
                wdt_cnt_q <= wdt_cnt_q + 1'b1;
            end
            if (cmd.cmd_valid) begin
                wdt_q <= 1'b0;
            end else if (trip_now) begin
                wdt_q <= 1'b1;
            end
        end
    end

    assign force_idle  = trip_now || wdt_q;
    assign wdt_tripped = wdt_q;
`else
    assign force_idle  = 1'b0;
    assign wdt_tripped = 1'b0;
`endif

    // State register: timebase, shadow/active command registers, channel FSMs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            sh_duty <= '0;
            sh_sign <= '0;
            duty_a  <= '0;
            sign_a  <= '0;
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= IDLE;
                dead_q[c]  <= '0;
            end
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                cnt_q <= (cnt_q == 8'd254) ? 8'd0 : cnt_q + 8'd1;
            end
            if (cmd.cmd_valid) begin
                sh_duty[0] <= cmd.motor1_count;
                sh_sign[0] <= cmd.motor1_sign;
                sh_duty[1] <= cmd.motor2_count;
                sh_sign[1] <= cmd.motor2_sign;
            end
            duty_a <= duty_d;
            sign_a <= sign_d;
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= state_d[c];
                dead_q[c]  <= dead_d[c];
            end
        end
    end

    // Next state: loads happen only on the boundary; DEAD counts down between boundaries.
    always_comb begin
        duty_d = duty_a;
        sign_d = sign_a;
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            dead_d[c]  = dead_q[c];
            if (boundary) begin
                duty_d[c] = force_idle ? 8'd0 : sh_duty[c];
                sign_d[c] = force_idle ? sign_a[c] : sh_sign[c];
                if (duty_d[c] == 8'd0) begin
                    state_d[c] = IDLE;
                    dead_d[c]  = '0;
                end else begin
                    case (state_q[c])
                        IDLE: begin
                            state_d[c] = RUN;
                        end
                        RUN: begin
                            if (sign_d[c] != sign_a[c]) begin
                                state_d[c] = DEAD;
                                dead_d[c]  = DW'(DEADTIME_CYCLES);
                            end
                        end
                        DEAD: begin
                            if (sign_d[c] != sign_a[c]) begin
                                dead_d[c] = DW'(DEADTIME_CYCLES);
                            end else if (dead_q[c] <= DW'(1)) begin
                                state_d[c] = RUN;
                                dead_d[c]  = '0;
                            end else begin
                                dead_d[c] = dead_q[c] - 1'b1;
                            end
                        end
                        default: begin
                            state_d[c] = IDLE;
                        end
                    endcase
                end
            end else if (state_q[c] == DEAD) begin
                if (dead_q[c] <= DW'(1)) begin
                    state_d[c] = RUN;
                    dead_d[c]  = '0;
                end else begin
                    dead_d[c] = dead_q[c] - 1'b1;
                end
            end
        end
    end

    // Output decode: only RUN drives the bridge; sign_a already holds the post-reversal sign.
    always_comb begin
        en_d   = '0;
        pins_d = '0;
        for (int c = 0; c < 2; c++) begin
            if (state_q[c] == RUN) begin
                en_d[c]   = (cnt_q < duty_a[c]);
                pins_d[c] = sign_a[c] ? 2'b01 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            enable12     <= 1'b0;
            enable34     <= 1'b0;
            a1           <= 1'b0;
            a2           <= 1'b0;
            a3           <= 1'b0;
            a4           <= 1'b0;
            period_start <= 1'b0;
        end else begin
            enable12     <= en_d[0];
            enable34     <= en_d[1];
            {a1, a2}     <= pins_d[0];
            {a3, a4}     <= pins_d[1];
            period_start <= boundary;
        end
    end

endmodule

// File: doc/dual_motor_pwm.md
Name: dual_motor_pwm

Overview:
- Two-channel PWM and H-bridge direction driver for the balance robot.
- Consumes the per-motor magnitude/sign commands (motor1_count/motor1_sign, motor2_count/motor2_sign).
- Drives the L293-style bridge pins enable12, enable34, a1..a4.
- Commands are double-buffered so they apply only at PWM period boundaries.
- A reversal inserts a coast dead-time before the direction pins flip, so the bridge never shoots through or hard-reverses.

Parameters:
- PRESCALE, 4: clk cycles per PWM tick (>=1).
- DEADTIME_CYCLES, 64: clk cycles of forced coast on a direction reversal (>=1).
- WDT_PERIODS, 16: PWM periods without cmd_valid before the watchdog trips. Used only with WATCHDOG_EN.

Ports:
- clk  in  1: system clock (6 MHz from HSOSC).
- nreset  in  1: asynchronous active-low reset.
- motor1_count  in  8: channel-1 duty magnitude; 0 = off, 255 = full on.
- motor1_sign  in  1: channel-1 direction; 0 = forward, 1 = reverse.
- motor2_count  in  8: channel-2 duty magnitude.
- motor2_sign  in  1: channel-2 direction.
- cmd_valid  in  1: single-cycle strobe; captures all four command inputs into the shadow registers.
- enable12  out  1: channel-1 bridge enable (PWM).
- enable34  out  1: channel-2 bridge enable (PWM).
- a1, a2  out  1 each: channel-1 direction pins.
- a3, a4  out  1 each: channel-2 direction pins.
- period_start  out  1: one-cycle pulse on the clk cycle the PWM counter wraps to 0.
- wdt_tripped  out  1: watchdog fault flag.

Behaviour:
- Reset (nreset low, async): all outputs 0; prescaler, PWM counter, dead-time counters, shadow and active registers 0; both channels IDLE.
- Timebase:
  - Prescaler counts 0..PRESCALE-1; tick asserted on terminal count.
  - PWM counter cnt advances on each tick over 0..254 (period = 255 ticks), then wraps to 0.
  - The wrap cycle is the period boundary; period_start pulses on it.
- Shadow: a cmd_valid cycle latches the inputs into the shadow registers on the next edge. A later strobe overwrites; the last value before a boundary wins.
- Boundary load: on the boundary, each channel copies shadow -> active (duty_a, sign_a). Latency from cmd_valid to effect: 1 clk + up to one full period.
- Direction-pin mapping:
  - duty_a = 0: pins 00 (coast).
  - sign_a = 0: a1/a2 = 10.
  - sign_a = 1: a1/a2 = 01.
  - Channel 2 maps identically onto a3/a4.
- Enable: enable = (cnt < duty_a), registered with 1 clk latency. duty 255 is always high; duty 0 is always low.
- Per-channel FSM:
  - IDLE -> RUN on a boundary load with duty != 0.
  - RUN -> IDLE on a boundary load with duty = 0. Pins 00, enable 0.
  - RUN -> DEAD on a boundary load where the new sign differs from the previous active sign and both old and new duty are nonzero.
    - In DEAD: enable = 0, pins = 00, dead counter loads DEADTIME_CYCLES.
    - On expiry: pins take the new sign, and the channel enters RUN mid-period, following the comparator for the rest of the period.
  - Sign change with old duty 0 (from IDLE): no DEAD; pins update directly at the boundary.
- Simultaneous events:
  - A boundary during DEAD (DEADTIME_CYCLES > period) reloads the active values. If the sign differs again, the dead counter restarts; otherwise the count continues.
  - cmd_valid on the boundary cycle latches into the shadow for the next boundary; the boundary uses the prior shadow.
- nreset asserted mid-period or mid-DEAD immediately returns all outputs to 0.
- Channels are fully independent apart from the shared timebase.

Optional Feature:
WATCHDOG_EN
- Defined:
  - A period counter increments on each boundary and clears on cmd_valid.
  - When it reaches WDT_PERIODS, wdt_tripped sets, and both channels are forced to duty 0 at that boundary: IDLE, pins 00.
  - The forced state holds until the next cmd_valid, which clears wdt_tripped on the following edge. The new command applies at the next boundary.
- Undefined: wdt_tripped is tied to 0 and there is no watchdog logic.

Test Plan:
- Reset: hold nreset low 10 cycles, then release with no cmd_valid -> all outputs 0 for 3 full periods; period_start pulses every 255*PRESCALE = 1020 clk.
- Duty 128 fwd on ch1, duty 255 rev on ch2, one cmd_valid -> from the next boundary:
  - enable12 high for 512 clk of every 1020; a1a2 = 10.
  - enable34 constantly high; a3a4 = 01.
- Two cmd_valid strobes in one period, ch1 duty 50 then 200 -> only 200 is applied at the boundary.
- Ch1 duty 100 fwd, then duty 100 rev -> at the boundary:
  - enable12 = 0 and a1a2 = 00 for exactly 64 clk.
  - Then a1a2 = 01 and enable12 follows cnt < 100.
- Ch1 duty 0 fwd -> duty 80 rev -> a1a2 = 01 at the boundary with no dead time.
- Assert nreset in the middle of DEAD -> outputs 0 within the same cycle.
- (WATCHDOG_EN) duty 200 both channels, then no strobes:
  - After 16 boundaries, wdt_tripped = 1 and all enables/pins are 0.
  - A new cmd_valid clears wdt_tripped next clk.
